// File: rtl/uart_rx_datapath_if.sv
// Host-side read port of the UART receiver: received word, status flags and the acknowledge.
interface uart_rx_datapath_if #(parameter int word_size = 8);
    logic                 read_done;
    logic [word_size-1:0] RCV_datareg;
    logic                 read_not_ready;
    logic                 Error1;
    logic                 Error2;
    logic                 Error3;

    modport master (input read_done, output RCV_datareg, read_not_ready, Error1, Error2, Error3);
    modport slave  (output read_done, input RCV_datareg, read_not_ready, Error1, Error2, Error3);
endinterface

// File: rtl/uart_rx_datapath.sv
// Oversampled UART receiver: synchronize, qualify start, sample mid-bit, hand word to host.
// Define UART_RX_PARITY_EN to receive and check one even-parity bit after the data bits.
module uart_rx_datapath #(
    parameter int word_size      = 8,
    parameter int oversample     = 8,
    parameter int size_bit_count = 3
) (
    input  logic                  Clock,
    input  logic                  rst_b,
    input  logic                  Serial_in,
    uart_rx_datapath_if.master    host
);
    localparam int SCW = $clog2(oversample);
    localparam int BCW = size_bit_count + 1;
`ifdef UART_RX_PARITY_EN
    localparam int NB = word_size + 1;
`else
    localparam int NB = word_size;
`endif
    localparam logic [SCW-1:0] SC_HALF = SCW'(oversample / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(oversample - 1);
    localparam logic [BCW-1:0] BC_STOP = BCW'(NB);

    typedef enum logic [1:0] {IDLE, STARTING, RECEIVING} state_t;

    state_t           state, state_nxt;
    logic             sync1, sin;
    logic [SCW-1:0]   sample_counter;
    logic [BCW-1:0]   bit_count;
    logic [NB-1:0]    shreg;
    logic             done_pend, stop_q, par_err;
    logic             sc_clr, sc_inc, bc_clr, shift_en, stop_en;
    logic [word_size-1:0] data_q;
    logic             rnr_q, err1_q, err2_q, err3_q;

    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!sin) state_nxt = STARTING;
            STARTING:  if (sin) state_nxt = IDLE;
                       else if (sample_counter == SC_HALF) state_nxt = RECEIVING;
            RECEIVING: if (sample_counter == SC_LAST && bit_count == BC_STOP) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sc_clr   = 1'b0;
        sc_inc   = 1'b0;
        bc_clr   = 1'b0;
        shift_en = 1'b0;
        stop_en  = 1'b0;
        case (state)
            IDLE: sc_clr = 1'b1;
            STARTING: begin
                if (!sin && sample_counter == SC_HALF) begin
                    sc_clr = 1'b1;
                    bc_clr = 1'b1;
                end else begin
                    sc_inc = 1'b1;
                end
            end
            RECEIVING: begin
                sc_inc = 1'b1;
                if (sample_counter == SC_LAST) begin
                    if (bit_count == BC_STOP) stop_en  = 1'b1;
                    else                      shift_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Synchronizer resets to the idle level so reset release never fakes a start bit.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            sync1          <= 1'b1;
            sin            <= 1'b1;
            sample_counter <= '0;
            bit_count      <= '0;
            shreg          <= '0;
            done_pend      <= 1'b0;
            stop_q         <= 1'b0;
        end else begin
            sync1 <= Serial_in;
            sin   <= sync1;
            if (sc_clr)      sample_counter <= '0;
            else if (sc_inc) sample_counter <= sample_counter + SCW'(1);
            if (bc_clr)        bit_count <= '0;
            else if (shift_en) bit_count <= bit_count + BCW'(1);
            if (shift_en) shreg <= {sin, shreg[NB-1:1]};
            done_pend <= stop_en;
            if (stop_en) stop_q <= sin;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign par_err = ^shreg;
`else
    assign par_err = 1'b0;
`endif

    // Completion wins over a same-cycle acknowledge, but the ack still clears the overrun source.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            data_q <= '0;
            rnr_q  <= 1'b0;
            err1_q <= 1'b0;
            err2_q <= 1'b0;
            err3_q <= 1'b0;
        end else if (done_pend) begin
            data_q <= shreg[word_size-1:0];
            rnr_q  <= 1'b1;
            err1_q <= rnr_q & ~host.read_done;
            err2_q <= ~stop_q;
            err3_q <= par_err;
        end else if (host.read_done) begin
            rnr_q  <= 1'b0;
            err1_q <= 1'b0;
            err2_q <= 1'b0;
            err3_q <= 1'b0;
        end
    end

    assign host.RCV_datareg    = data_q;
    assign host.read_not_ready = rnr_q;
    assign host.Error1         = err1_q;
    assign host.Error2         = err2_q;
    assign host.Error3         = err3_q;
endmodule

// File: tb/tb_uart_rx_datapath.sv
// Randomized frame bench for uart_rx_datapath against a frame-level host-visible model.
module tb_uart_rx_datapath;
    localparam int W  = 8;
    localparam int OS = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic Clock = 1'b0;
    logic rst_b = 1'b0;
    logic Serial_in = 1'b1;
    bit   cmp_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [W-1:0] m_data = '0;
    bit m_rnr = 0, m_e1 = 0, m_e2 = 0, m_e3 = 0;

    uart_rx_datapath_if #(.word_size(W)) bus ();

    uart_rx_datapath #(.word_size(W), .oversample(OS), .size_bit_count(3)) dut (
        .Clock     (Clock),
        .rst_b     (rst_b),
        .Serial_in (Serial_in),
        .host      (bus.master)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (cmp_en) begin
            check("data", 32'(bus.RCV_datareg), 32'(m_data));
            check("read_not_ready", 32'(bus.read_not_ready), 32'(m_rnr));
            check("Error1", 32'(bus.Error1), 32'(m_e1));
            check("Error2", 32'(bus.Error2), 32'(m_e2));
            check("Error3", 32'(bus.Error3), 32'(m_e3));
        end
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic model_reset;
        m_data = '0; m_rnr = 0; m_e1 = 0; m_e2 = 0; m_e3 = 0;
    endtask

    task automatic pulse_ack;
        bus.read_done = 1'b1;
        tick();
        bus.read_done = 1'b0;
        if (m_rnr) begin
            m_rnr = 0; m_e1 = 0; m_e2 = 0; m_e3 = 0;
        end
    endtask

    // Word becomes visible on the edge that ends the stop-bit window.
    task automatic send_frame(input logic [W-1:0] d, input bit pbit, input bit stop, input bit ack_on_done);
        Serial_in = 1'b0;
        repeat (OS) tick();
        for (int k = 0; k < W; k++) begin
            Serial_in = d[k];
            repeat (OS) tick();
        end
        if (PAR) begin
            Serial_in = pbit;
            repeat (OS) tick();
        end
        Serial_in = stop;
        repeat (OS - 1) tick();
        if (ack_on_done) bus.read_done = 1'b1;
        tick();
        bus.read_done = 1'b0;
        m_e1   = m_rnr && !ack_on_done;
        m_rnr  = 1;
        m_data = d;
        m_e2   = !stop;
        m_e3   = PAR ? ((^d) ^ pbit) : 1'b0;
        Serial_in = 1'b1;
        repeat (3) tick();
    endtask

    task automatic glitch(input int n);
        Serial_in = 1'b0;
        repeat (n) tick();
        Serial_in = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        bus.read_done = 1'b0;
        repeat (3) tick();
        model_reset();
        check("reset_data", 32'(bus.RCV_datareg), 32'h0);
        check("reset_rnr", 32'(bus.read_not_ready), 32'h0);
        rst_b = 1'b1;
        cmp_en = 1'b1;
        repeat (10) tick();

        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check("A5_data", 32'(bus.RCV_datareg), 32'hA5);
        check("A5_rnr", 32'(bus.read_not_ready), 32'h1);
        check("A5_err", {29'h0, bus.Error1, bus.Error2, bus.Error3}, 32'h0);
        pulse_ack();
        check("A5_ack_rnr", 32'(bus.read_not_ready), 32'h0);

        glitch(3);
        check("glitch_rnr", 32'(bus.read_not_ready), 32'h0);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("3C_data", 32'(bus.RCV_datareg), 32'h3C);
        check("3C_err2", 32'(bus.Error2), 32'h1);
        pulse_ack();
        check("3C_ack_err2", 32'(bus.Error2), 32'h0);

        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        check("22_data", 32'(bus.RCV_datareg), 32'h22);
        check("22_err1", 32'(bus.Error1), 32'h1);
        pulse_ack();
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        check("22ack_err1", 32'(bus.Error1), 32'h0);
        check("22ack_rnr", 32'(bus.read_not_ready), 32'h1);

`ifdef UART_RX_PARITY_EN
        pulse_ack();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check("07p1_err3", 32'(bus.Error3), 32'h0);
        pulse_ack();
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        check("07p0_err3", 32'(bus.Error3), 32'h1);
        check("07p0_data", 32'(bus.RCV_datareg), 32'h07);
`endif

        // Asynchronous reset in the middle of a frame, off the clock edge.
        Serial_in = 1'b0;
        repeat (30) tick();
        #2;
        rst_b = 1'b0;
        #1;
        model_reset();
        check("midrst_data", 32'(bus.RCV_datareg), 32'h0);
        check("midrst_flags", {28'h0, bus.read_not_ready, bus.Error1, bus.Error2, bus.Error3}, 32'h0);
        Serial_in = 1'b1;
        repeat (3) tick();
        rst_b = 1'b1;
        repeat (90) tick();
        check("postrst_rnr", 32'(bus.read_not_ready), 32'h0);

        for (int f = 0; f < 40; f++) begin
            logic [W-1:0] d;
            bit stop, pbit, ack;
            d    = W'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            pbit = (^d) ^ ($urandom_range(0, 3) == 0);
            ack  = ($urandom_range(0, 4) == 0);
            send_frame(d, pbit, stop, ack);
            if ($urandom_range(0, 2) == 0) glitch(int'($urandom_range(1, 4)));
            if ($urandom_range(0, 1) == 0) pulse_ack();
            repeat ($urandom_range(0, 6)) tick();
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
